// File: rtl/pal_mc_pkg.sv
// pal_mc_pkg: shared types and sizing helpers for the PAL macrocell block.
//   state_e      - configuration FSM state (UNCFG, LOAD, RUN)
//   or_base()    - chain offset of the OR plane (AND plane occupies [or_base-1:0])
//   mode_base()  - chain offset of the macrocell mode bits
//   chain_len()  - total configuration chain length L
//   word_cnt()   - configuration words K needed to fill the chain
package pal_mc_pkg;

    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_e;

    function automatic int unsigned or_base(input int unsigned n, input int unsigned p);
        return 2 * n * p;
    endfunction

    function automatic int unsigned mode_base(input int unsigned n, input int unsigned m,
                                              input int unsigned p);
        return 2 * n * p + p * m;
    endfunction

    function automatic int unsigned chain_len(input int unsigned n, input int unsigned m,
                                              input int unsigned p);
        return mode_base(n, m, p) + m;
    endfunction

    function automatic int unsigned word_cnt(input int unsigned l, input int unsigned w);
        return (l + w - 1) / w;
    endfunction

endpackage

// File: rtl/pal_mc_array.sv
// pal_mc_array: purely combinational AND/OR planes of the PAL.
// Ports:
//   chain   in  AND plane bits [or_base-1:0] followed by OR plane bits
//   in_vars in  N logic inputs
//   sums    out M OR sums
// A term with no connected literal is 1; a sum with no connected term is 0.
module pal_mc_array
    import pal_mc_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned M = 8,
    parameter int unsigned P = 8
) (
    input  logic [mode_base(N, M, P)-1:0] chain,
    input  logic [N-1:0]                  in_vars,
    output logic [M-1:0]                  sums
);

    localparam int unsigned OB = or_base(N, P);

    logic [P-1:0] terms;

    // Literal 2n is x[n], literal 2n+1 is ~x[n]; a connected false literal kills the term.
    always_comb begin
        terms = '1;
        for (int unsigned p = 0; p < P; p++) begin
            for (int unsigned n = 0; n < N; n++) begin
                if (chain[p + 2 * n * P] && !in_vars[n]) begin
                    terms[p] = 1'b0;
                end
                if (chain[p + (2 * n + 1) * P] && in_vars[n]) begin
                    terms[p] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        sums = '0;
        for (int unsigned m = 0; m < M; m++) begin
            for (int unsigned p = 0; p < P; p++) begin
                if (chain[OB + p + m * P] && terms[p]) begin
                    sums[m] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pal_mc.sv
// pal_mc: configurable PAL with a serially loaded configuration chain and
// per-output combinational/registered macrocells.
// Ports:
//   CLK, RES_N            clock, asynchronous active-low reset
//   CFG_START             begin (or restart) a configuration load
//   CFG_VALID/CFG_READY   word handshake, CFG_DATA is the W-bit word
//   CFG_DONE              configuration complete, logic active
//   CFG_DOUT              (only with PAL_MC_READBACK_EN) top word of the chain
//   EN                    clock enable for registered macrocells
//   INPUT_VARS            N logic inputs
//   OUTPUT_VALS           M logic outputs
// Optional feature macro: PAL_MC_READBACK_EN.
module pal_mc
    import pal_mc_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned M = 8,
    parameter int unsigned P = 8,
    parameter int unsigned W = 8
) (
    input  logic         CLK,
    input  logic         RES_N,
    input  logic         CFG_START,
    input  logic         CFG_VALID,
    output logic         CFG_READY,
    input  logic [W-1:0] CFG_DATA,
    output logic         CFG_DONE,
`ifdef PAL_MC_READBACK_EN
    output logic [W-1:0] CFG_DOUT,
`endif
    input  logic         EN,
    input  logic [N-1:0] INPUT_VARS,
    output logic [M-1:0] OUTPUT_VALS
);

    localparam int unsigned L     = chain_len(N, M, P);
    localparam int unsigned K     = word_cnt(L, W);
    localparam int unsigned CW    = K * W;
    localparam int unsigned MB    = mode_base(N, M, P);
    localparam int unsigned CNT_W = (K > 1) ? $clog2(K) : 1;

    state_e             state_q, state_d;
    logic [CW-1:0]      chain_q, chain_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [M-1:0]       mc_q, mc_d;
    logic [M-1:0]       sums;

    pal_mc_array #(
        .N (N),
        .M (M),
        .P (P)
    ) u_array (
        .chain   (chain_q[MB-1:0]),
        .in_vars (INPUT_VARS),
        .sums    (sums)
    );

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            state_q <= UNCFG;
            chain_q <= '0;
            cnt_q   <= '0;
            mc_q    <= '0;
        end else begin
            state_q <= state_d;
            chain_q <= chain_d;
            cnt_q   <= cnt_d;
            mc_q    <= mc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        chain_d = chain_q;
        cnt_d   = cnt_q;
        mc_d    = mc_q;
        unique case (state_q)
            UNCFG, RUN: begin
                if (CFG_START) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    mc_d    = '0;
                end else if (state_q == RUN && EN) begin
                    mc_d = sums;
                end
            end
            LOAD: begin
                // A restart wins over a word offered in the same cycle.
                if (CFG_START) begin
                    cnt_d = '0;
                end else if (CFG_VALID) begin
                    // Shift form avoids an empty slice when the chain is a single word.
                    chain_d = (chain_q << W) | CW'(CFG_DATA);
                    if (cnt_q == CNT_W'(K - 1)) begin
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = UNCFG;
        endcase
    end

    assign CFG_READY = (state_q == LOAD);
    assign CFG_DONE  = (state_q == RUN);

`ifdef PAL_MC_READBACK_EN
    assign CFG_DOUT = chain_q[CW-1 -: W];
`endif

    always_comb begin
        OUTPUT_VALS = '0;
        if (state_q == RUN) begin
            for (int unsigned m = 0; m < M; m++) begin
                OUTPUT_VALS[m] = chain_q[MB + m] ? mc_q[m] : sums[m];
            end
        end
    end

endmodule

// File: tb/tb_pal_mc.sv
// tb_pal_mc: randomized scoreboard bench for pal_mc (N=M=P=4, W=8).
// The driver steps one cycle at a time, computes the expected outputs from a
// high-level model and queues them; a negedge monitor pops and compares.
// Readback checks are compiled in when PAL_MC_READBACK_EN is defined.
module tb_pal_mc;

    localparam int unsigned N  = 4;
    localparam int unsigned M  = 4;
    localparam int unsigned P  = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned L  = 2 * N * P + P * M + M;  // 52
    localparam int unsigned K  = (L + W - 1) / W;         // 7
    localparam int unsigned CW = K * W;                   // 56
    localparam int unsigned OB = 2 * N * P;               // OR plane base
    localparam int unsigned MB = 2 * N * P + P * M;       // mode bits base

    logic         CLK = 1'b0;
    logic         RES_N = 1'b0;
    logic         CFG_START = 1'b0;
    logic         CFG_VALID = 1'b0;
    logic [W-1:0] CFG_DATA = '0;
    logic         EN = 1'b0;
    logic [N-1:0] INPUT_VARS = '0;
    logic         CFG_READY;
    logic         CFG_DONE;
    logic [M-1:0] OUTPUT_VALS;
`ifdef PAL_MC_READBACK_EN
    logic [W-1:0] dout;
`endif

    pal_mc #(
        .N (N),
        .M (M),
        .P (P),
        .W (W)
    ) dut (
        .CLK         (CLK),
        .RES_N       (RES_N),
        .CFG_START   (CFG_START),
        .CFG_VALID   (CFG_VALID),
        .CFG_READY   (CFG_READY),
        .CFG_DATA    (CFG_DATA),
        .CFG_DONE    (CFG_DONE),
`ifdef PAL_MC_READBACK_EN
        .CFG_DOUT    (dout),
`endif
        .EN          (EN),
        .INPUT_VARS  (INPUT_VARS),
        .OUTPUT_VALS (OUTPUT_VALS)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string        name;
        logic [M-1:0] out;
        logic         ready;
        logic         done;
        bit           dchk;
        logic [W-1:0] dout;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    bit   sample = 0;

    // Behavioural model: loading/configured flags, accepted-word count, chain image, FFs.
    bit            m_load;
    bit            m_run;
    int            m_acc;
    logic [CW-1:0] m_chain;
    logic [M-1:0]  m_ff;

    task automatic model_reset();
        m_load  = 0;
        m_run   = 0;
        m_acc   = 0;
        m_chain = '0;
        m_ff    = '0;
    endtask

    // Sum-of-products evaluation straight from the chain bit assignment rules.
    function automatic logic [M-1:0] eval(input logic [CW-1:0] c, input logic [N-1:0] x);
        logic [M-1:0] r;
        bit           t;
        r = '0;
        for (int m = 0; m < M; m++) begin
            for (int p = 0; p < P; p++) begin
                t = 1;
                for (int n = 0; n < N; n++) begin
                    if (c[p + 2 * n * P] == 1'b1 && x[n] == 1'b0) t = 0;
                    if (c[p + (2 * n + 1) * P] == 1'b1 && x[n] == 1'b1) t = 0;
                end
                if (c[OB + p + m * P] == 1'b1 && t) r[m] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic step(input logic start, input logic valid, input logic [W-1:0] data,
                        input logic en, input logic [N-1:0] x, input string name);
        exp_t         e;
        logic [M-1:0] comb;
        CFG_START  = start;
        CFG_VALID  = valid;
        CFG_DATA   = data;
        EN         = en;
        INPUT_VARS = x;
        comb    = eval(m_chain, x);
        e.name  = name;
        e.ready = m_load;
        e.done  = m_run;
        e.out   = '0;
        if (m_run) begin
            for (int m = 0; m < M; m++) e.out[m] = m_chain[MB + m] ? m_ff[m] : comb[m];
        end
        e.dchk = m_load && valid && !start;
        e.dout = m_chain[CW-1 -: W];
        exp_q.push_back(e);
        sample = 1;
        @(posedge CLK);
        #1;
        if (!RES_N) begin
            model_reset();
        end else if (start) begin
            if (!m_load) begin
                m_run = 0;
                m_ff  = '0;
            end
            m_load = 1;
            m_acc  = 0;
        end else if (m_load && valid) begin
            m_chain = {m_chain[CW-W-1:0], data};
            m_acc++;
            if (m_acc == K) begin
                m_load = 0;
                m_run  = 1;
            end
        end else if (m_run && en) begin
            m_ff = comb;
        end
    endtask

    task automatic rand_step(input string name);
        step(1'b0, 1'($urandom_range(1)), W'($urandom), 1'($urandom_range(1)), N'($urandom),
             name);
    endtask

    // gap: 0 = back-to-back, 1 = valid pattern 1,0,0,1,..., 2 = random valid.
    task automatic load(input logic [CW-1:0] cfg, input int gap, input int restart_at,
                        input string name);
        int   guard;
        bit   restarted;
        logic v;
        guard     = 0;
        restarted = 0;
        step(1'b1, 1'b0, '0, 1'($urandom_range(1)), N'($urandom), {name, "_start"});
        while (!m_run && guard < 300) begin
            guard++;
            if (!restarted && restart_at >= 0 && m_acc == restart_at) begin
                restarted = 1;
                step(1'b1, 1'b1, W'($urandom), 1'b1, N'($urandom), {name, "_restart"});
            end else begin
                if (gap == 0) v = 1'b1;
                else if (gap == 1) v = (guard % 3 == 1);
                else v = 1'($urandom_range(1));
                step(1'b0, v, cfg[CW - 1 - W * m_acc -: W], 1'($urandom_range(1)),
                     N'($urandom), {name, "_load"});
            end
        end
    endtask

    function automatic logic [CW-1:0] cfg_a();
        logic [CW-1:0] c;
        c = '0;
        c[0 + 0 * P]       = 1'b1;   // term0 <- x0
        c[0 + 3 * P]       = 1'b1;   // term0 <- ~x1
        c[OB + 0 + 0 * P]  = 1'b1;   // out0 <- term0
        c[OB + 0 + 1 * P]  = 1'b1;   // out1 <- term0
        c[OB + 1 + 3 * P]  = 1'b1;   // out3 <- term1 (no literals, always 1)
        c[MB + 1]          = 1'b1;   // out1 registered
        c[CW-1:L]          = 4'ha;   // don't-care padding
        return c;
    endfunction

    function automatic logic [CW-1:0] cfg_rand();
        logic [63:0] r;
        r = {$urandom, $urandom};
        r[2*N*P-1:0] = $urandom & $urandom & $urandom;  // sparse AND plane
        return r[CW-1:0];
    endfunction

    always @(negedge CLK) begin
        if (sample) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL queue_empty: monitor sampled with no expectation queued");
            end else begin
                mon_e = exp_q.pop_front();
                if ({OUTPUT_VALS, CFG_READY, CFG_DONE} !== {mon_e.out, mon_e.ready, mon_e.done})
                begin
                    errors++;
                    $display("FAIL %s: got out=%b ready=%b done=%b, want out=%b ready=%b done=%b",
                             mon_e.name, OUTPUT_VALS, CFG_READY, CFG_DONE, mon_e.out,
                             mon_e.ready, mon_e.done);
                end
`ifdef PAL_MC_READBACK_EN
                if (mon_e.dchk) begin
                    checks++;
                    if (dout !== mon_e.dout) begin
                        errors++;
                        $display("FAIL %s_dout: got %h, want %h", mon_e.name, dout, mon_e.dout);
                    end
                end
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(posedge CLK);
        #1;
        // Held in reset
        step(1'b0, 1'b1, 8'hff, 1'b1, 4'hf, "in_reset0");
        step(1'b1, 1'b1, 8'hff, 1'b1, 4'h5, "in_reset1");
        RES_N = 1'b1;
        // Unconfigured: outputs stay 0, stray CFG_VALID ignored
        for (int i = 0; i < 10; i++) rand_step("uncfg");

        // Config A, back-to-back words
        load(cfg_a(), 0, -1, "cfg_a");
        step(1'b0, 1'b0, '0, 1'b1, 4'b0001, "a_comb_hit");
        step(1'b0, 1'b0, '0, 1'b1, 4'b0011, "a_comb_miss");
        step(1'b0, 1'b0, '0, 1'b1, 4'b0011, "a_reg_fall");
        step(1'b0, 1'b0, '0, 1'b1, 4'b0001, "a_reg_low");
        step(1'b0, 1'b0, '0, 1'b0, 4'b0011, "a_reg_rise");
        step(1'b0, 1'b0, '0, 1'b0, 4'b0011, "a_en0_hold1");
        step(1'b0, 1'b0, '0, 1'b0, 4'b0000, "a_en0_hold2");
        for (int i = 0; i < 15; i++) rand_step("a_rand");

        // Reload from RUN with gapped valid; readback shows config A words
        load(cfg_rand(), 1, -1, "cfg_gap");
        for (int i = 0; i < 20; i++) rand_step("gap_rand");

        // Restart after three accepted words
        load(cfg_rand(), 2, 3, "cfg_restart");
        for (int i = 0; i < 20; i++) rand_step("restart_rand");

        for (int k = 0; k < 3; k++) begin
            load(cfg_rand(), 2, -1, "cfg_rnd");
            for (int i = 0; i < 25; i++) rand_step("rnd_run");
        end

        // Reset in the middle of a load
        step(1'b1, 1'b0, '0, 1'b1, 4'h0, "midrst_start");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, W'($urandom), 1'b1, N'($urandom),
                                         "midrst_load");
        RES_N = 1'b0;
        model_reset();
        step(1'b0, 1'b1, 8'h5a, 1'b1, 4'hf, "midrst_low0");
        step(1'b0, 1'b1, 8'h5a, 1'b1, 4'h1, "midrst_low1");
        RES_N = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, W'($urandom), 1'b1, N'($urandom),
                                         "midrst_after");
        load(cfg_a(), 0, -1, "cfg_a2");
        step(1'b0, 1'b0, '0, 1'b1, 4'b0001, "a2_comb_hit");
        step(1'b0, 1'b0, '0, 1'b1, 4'b0011, "a2_comb_miss");
        for (int i = 0; i < 10; i++) rand_step("a2_rand");

        sample = 0;
        @(negedge CLK);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pal_mc.md
PAL_MC -- requirements
Module: pal_mc

Interface
REQ-001 Parameter N, default 8: number of input variables.
REQ-002 Parameter M, default 8: number of outputs/macrocells.
REQ-003 Parameter P, default 8: number of product terms.
REQ-004 Parameter W, default 8: configuration word width, 1 <= W <= 32.
REQ-005 Port CLK  in  1: the single clock; all state updates on the rising edge.
REQ-006 Port RES_N  in  1: asynchronous active-low reset.
REQ-007 Port CFG_START  in  1: one-cycle request to begin a configuration load.
REQ-008 Port CFG_VALID  in  1: CFG_DATA valid.
REQ-009 Port CFG_READY  out  1: block accepts a configuration word.
REQ-010 Port CFG_DATA  in  W: configuration word.
REQ-011 Port CFG_DONE  out  1: configuration complete, logic active.
REQ-012 Port EN  in  1: clock enable for registered macrocells.
REQ-013 Port INPUT_VARS  in  N: logic inputs.
REQ-014 Port OUTPUT_VALS  out  M: logic outputs.

Function
REQ-015 Chain length L = 2NP + PM + M; word count K = ceil(L/W); the storage register is K*W bits, and the top K*W-L bits are don't-care.
REQ-016 Chain bits [2NP-1:0] form the AND plane: bit p + j*P connects literal j to term p, with j = 2n for INPUT_VARS[n] and j = 2n+1 for ~INPUT_VARS[n]; 1 = connected.
REQ-017 Chain bits [2NP+PM-1:2NP] form the OR plane: offset p + m*P connects term p to output m; 1 = connected.
REQ-018 Chain bits [L-1:2NP+PM] are the macrocell modes: offset m = 1 makes output m registered, 0 makes it combinational.
REQ-019 A product term with no connected literal evaluates to 1; an OR sum with no connected term evaluates to 0.
REQ-020 The FSM has three states: UNCFG (after reset), LOAD and RUN.
REQ-021 UNCFG or RUN with CFG_START=1 goes to LOAD next cycle; the word counter clears, all macrocell FFs clear and CFG_DONE drops.
REQ-022 In LOAD, CFG_READY=1 and each CFG_VALID&CFG_READY cycle shifts the chain by W: chain <= {chain[K*W-W-1:0], CFG_DATA}, and the counter increments.
REQ-023 The K-th accepted word moves the FSM to RUN next cycle, with CFG_DONE=1 from that cycle on and CFG_READY=0.
REQ-024 CFG_START asserted during LOAD restarts the count at 0, and any word offered in that same cycle is discarded.
REQ-025 In UNCFG and LOAD, OUTPUT_VALS = 0.
REQ-026 In RUN, a combinational output equals its OR sum of the current INPUT_VARS with zero-cycle latency.
REQ-027 In RUN, a registered output's FF captures its OR sum on each edge with EN=1 and holds when EN=0; OUTPUT_VALS shows the FF value, giving one-cycle latency.
REQ-028 CFG_VALID outside LOAD is ignored; CFG_READY=0 outside LOAD.

Reset
REQ-029 RES_N=0 asynchronously forces: state UNCFG, chain all zeros, counter 0, macrocell FFs 0, OUTPUT_VALS 0, CFG_READY 0, CFG_DONE 0.
REQ-030 A reset during LOAD discards any partial configuration; a new CFG_START is needed afterwards.

Configuration
REQ-031 With macro PAL_MC_READBACK_EN defined, output port CFG_DOUT (W bits) is present and equals chain[K*W-1:K*W-W], the word shifted out by the next accept, which allows readback and daisy-chaining.
REQ-032 Without PAL_MC_READBACK_EN, the CFG_DOUT port does not exist and all other behaviour is unchanged.

Structure
REQ-033 Package pal_mc_pkg holds the FSM state enum (UNCFG, LOAD, RUN) and constant functions for L, K and the plane base offsets.
REQ-034 Sub-module pal_mc_array holds the purely combinational AND/OR planes, taking the chain and INPUT_VARS and producing the M OR sums; pal_mc holds the FSM, chain register, counter and macrocells.

Verification (N=M=P=4, W=8, so L=52, K=7)
REQ-035 Reset release -> OUTPUT_VALS=0, CFG_READY=0, CFG_DONE=0, and 10 cycles of random INPUT_VARS keep outputs at 0.
REQ-036 Load term0 = x0&~x1 with OUT0 combinational from term0 -> INPUT_VARS=4'b0001 gives OUTPUT_VALS[0]=1 in the same cycle; 4'b0011 gives 0.
REQ-037 OUT1 registered from term0 with EN=1, INPUT_VARS stepping 0001->0011 -> OUTPUT_VALS[1] steps 1->0 one cycle later; with EN=0, OUTPUT_VALS[1] holds.
REQ-038 Load with CFG_VALID gaps (pattern 1,0,0,1,...) -> exactly 7 accepts; CFG_DONE rises the cycle after the 7th accept and CFG_READY drops.
REQ-039 CFG_START after 3 accepted words -> 7 further words are needed; CFG_START in RUN -> OUTPUT_VALS=0 and CFG_DONE=0 until reload completes.
REQ-040 With PAL_MC_READBACK_EN, load config A and then load config B -> the 7 CFG_DOUT values sampled at accepts equal A's words in order; RES_N pulsed mid-load -> the bench checks UNCFG state and zero outputs.
